reg_file_rename: RTL and testbench

- Architectural register file plus rename table: 32 × 32-bit registers, each with a busy bit and a ROB tag naming its pending producer.
- Sits between the decoder/issue stage (upstream) and the reorder buffer (downstream).
- Takes the ROB's per-cycle commit write and new-tail allocation, and resolves decoder source operands.
- Each source resolves to a value or a ROB tag; ROB-ready results and same-cycle commits are forwarded.

---
 rtl/reg_file_rename_pkg.sv | 14 +
 rtl/reg_file_rename_operand_resolve.sv | 47 ++++
 rtl/reg_file_rename.sv | 129 ++++++++++++
 tb/tb_reg_file_rename.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/reg_file_rename_pkg.sv
// Shared constants for the rename register file; mirrors the ROB's sizing.
// Also holds a small helper for recognising writable (non-x0) register ids.
package reg_file_rename_pkg;

    localparam int ROB_WIDTH_BIT_DEF = 4;
    localparam int REG_NUM           = 32;
    localparam int REG_ID_W          = 5;
    localparam int XLEN              = 32;

    function automatic logic reg_writable(input logic [REG_ID_W-1:0] id);
        return (id != {REG_ID_W{1'b0}});
    endfunction

endpackage

// File: rtl/reg_file_rename_operand_resolve.sv
// Resolves one decoder source operand to either a value or a pending ROB tag,
// applying commit bypass and ROB-result forwarding on top of the held state.
module reg_file_rename_operand_resolve
    import reg_file_rename_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
    input  logic [REG_ID_W-1:0]      src_idx,
    input  logic                     reg_busy,
    input  logic [XLEN-1:0]          reg_val,
    input  logic [ROB_WIDTH_BIT-1:0] reg_tag,
    input  logic                     rdy_in,
    input  logic [REG_ID_W-1:0]      write_reg_id,
    input  logic [XLEN-1:0]          write_val,
    input  logic [ROB_WIDTH_BIT-1:0] write_rob_id,
    input  logic                     rob_ready,
    input  logic [XLEN-1:0]          rob_val,
    output logic [ROB_WIDTH_BIT-1:0] rob_id,
    output logic                     op_busy,
    output logic [XLEN-1:0]          op_val,
    output logic [ROB_WIDTH_BIT-1:0] op_tag
);

    // Priority chain: x0, idle register, commit bypass, ROB forward, pending.
    always_comb begin
        rob_id  = {ROB_WIDTH_BIT{1'b0}};
        op_busy = 1'b0;
        op_val  = {XLEN{1'b0}};
        op_tag  = {ROB_WIDTH_BIT{1'b0}};
        if (!reg_writable(src_idx)) begin
            op_busy = 1'b0;
        end else if (!reg_busy) begin
            op_val = reg_val;
        end else begin
            rob_id = reg_tag;
            if (rdy_in && (write_reg_id == src_idx) && (write_rob_id == reg_tag)) begin
                op_val = write_val;
            end else if (rob_ready) begin
                op_val = rob_val;
            end else begin
                op_busy = 1'b1;
                op_tag  = reg_tag;
            end
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// Takes ROB commits and new allocations; resolves two source operands combinationally.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF,
    parameter int NUM_REGS      = REG_NUM
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [REG_ID_W-1:0]      write_reg_id,
    input  logic [XLEN-1:0]          write_val,
    input  logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    input  logic [REG_ID_W-1:0]      new_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
    input  logic [REG_ID_W-1:0]      rs1_idx,
    input  logic [REG_ID_W-1:0]      rs2_idx,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    input  logic                     rob_rs1_ready,
    input  logic [XLEN-1:0]          rob_rs1_val,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs2_ready,
    input  logic [XLEN-1:0]          rob_rs2_val,
    output logic                     rs1_busy,
    output logic [XLEN-1:0]          rs1_val,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic                     rs2_busy,
    output logic [XLEN-1:0]          rs2_val,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag
);

    logic [XLEN-1:0]          val_q  [NUM_REGS];
    logic [XLEN-1:0]          val_d  [NUM_REGS];
    logic                     busy_q [NUM_REGS];
    logic                     busy_d [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] tag_q  [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] tag_d  [NUM_REGS];

    logic commit_en_s;
    logic rename_en_s;

    assign commit_en_s = rdy_in && reg_writable(write_reg_id);
    assign rename_en_s = rdy_in && !clear && reg_writable(new_reg_id);

    // Next-state: commit writes the value, rename owns busy/tag, clear drops all ownership.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_en_s) begin
            val_d[write_reg_id] = write_val;
            // A younger producer (or a same-cycle rename) keeps the register busy.
            if (busy_q[write_reg_id] && (tag_q[write_reg_id] == write_ROB_id) &&
                !(rename_en_s && (new_reg_id == write_reg_id))) begin
                busy_d[write_reg_id] = 1'b0;
            end else begin
                busy_d[write_reg_id] = busy_q[write_reg_id];
            end
        end else begin
            val_d = val_q;
        end
        if (rdy_in && clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = {ROB_WIDTH_BIT{1'b0}};
            end
        end else if (rename_en_s) begin
            busy_d[new_reg_id] = 1'b1;
            tag_d[new_reg_id]  = new_ROB_id;
        end else begin
            tag_d = tag_q;
        end
        val_d[0]  = {XLEN{1'b0}};
        busy_d[0] = 1'b0;
        tag_d[0]  = {ROB_WIDTH_BIT{1'b0}};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i]  <= {XLEN{1'b0}};
                busy_q[i] <= 1'b0;
                tag_q[i]  <= {ROB_WIDTH_BIT{1'b0}};
            end
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    reg_file_rename_operand_resolve #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_rs1 (
        .src_idx      (rs1_idx),
        .reg_busy     (busy_q[rs1_idx]),
        .reg_val      (val_q[rs1_idx]),
        .reg_tag      (tag_q[rs1_idx]),
        .rdy_in       (rdy_in),
        .write_reg_id (write_reg_id),
        .write_val    (write_val),
        .write_rob_id (write_ROB_id),
        .rob_ready    (rob_rs1_ready),
        .rob_val      (rob_rs1_val),
        .rob_id       (rob_rs1_id),
        .op_busy      (rs1_busy),
        .op_val       (rs1_val),
        .op_tag       (rs1_tag)
    );

    reg_file_rename_operand_resolve #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_rs2 (
        .src_idx      (rs2_idx),
        .reg_busy     (busy_q[rs2_idx]),
        .reg_val      (val_q[rs2_idx]),
        .reg_tag      (tag_q[rs2_idx]),
        .rdy_in       (rdy_in),
        .write_reg_id (write_reg_id),
        .write_val    (write_val),
        .write_rob_id (write_ROB_id),
        .rob_ready    (rob_rs2_ready),
        .rob_val      (rob_rs2_val),
        .rob_id       (rob_rs2_id),
        .op_busy      (rs2_busy),
        .op_val       (rs2_val),
        .op_tag       (rs2_tag)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed self-checking bench for reg_file_rename: rename, commit, bypass,
// forwarding, clear, stall and x0 behaviour with hand-computed expectations.
module tb_reg_file_rename;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic [4:0]  write_reg_id, new_reg_id, rs1_idx, rs2_idx;
    logic [31:0] write_val, rob_rs1_val, rob_rs2_val;
    logic [3:0]  write_ROB_id, new_ROB_id, rob_rs1_id, rob_rs2_id, rs1_tag, rs2_tag;
    logic        rob_rs1_ready, rob_rs2_ready, rs1_busy, rs2_busy;
    logic [31:0] rs1_val, rs2_val;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    reg_file_rename #(.ROB_WIDTH_BIT(4), .NUM_REGS(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .write_reg_id(write_reg_id), .write_val(write_val), .write_ROB_id(write_ROB_id),
        .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rob_rs1_id(rob_rs1_id), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
        .rob_rs2_id(rob_rs2_id), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val),
        .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_tag(rs2_tag)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
        write_reg_id = 5'd0; write_val = 32'd0; write_ROB_id = 4'd0;
        new_reg_id = 5'd0; new_ROB_id = 4'd0;
        rob_rs1_ready = 1'b0; rob_rs1_val = 32'd0;
        rob_rs2_ready = 1'b0; rob_rs2_val = 32'd0;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        rs1_idx = 5'd5; rs2_idx = 5'd0; #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy got %b want 0", rs1_busy); end
        checks++; if (rs1_val !== 32'd0) begin errors++; $display("FAIL reset_rs1_val got %h want 0", rs1_val); end
        checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_rs2_busy got %b want 0", rs2_busy); end
        checks++; if (rs2_val !== 32'd0) begin errors++; $display("FAIL reset_rs2_val got %h want 0", rs2_val); end
        checks++; if (rob_rs1_id !== 4'd0) begin errors++; $display("FAIL reset_rob_rs1_id got %0d want 0", rob_rs1_id); end
    endtask

    task automatic test_rename_forward();
        idle();
        new_reg_id = 5'd5; new_ROB_id = 4'd3; rs1_idx = 5'd5; rs2_idx = 5'd5; #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL rename_same_cycle_old_map got %b want 0", rs1_busy); end
        tick(); new_reg_id = 5'd0; #1;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL rename_busy got %b want 1", rs1_busy); end
        checks++; if (rs1_tag !== 4'd3) begin errors++; $display("FAIL rename_tag got %0d want 3", rs1_tag); end
        checks++; if (rob_rs1_id !== 4'd3) begin errors++; $display("FAIL rename_rob_id got %0d want 3", rob_rs1_id); end
        checks++; if (rob_rs2_id !== 4'd3) begin errors++; $display("FAIL rename_rob_rs2_id got %0d want 3", rob_rs2_id); end
        rob_rs1_ready = 1'b1; rob_rs1_val = 32'hDEADBEEF;
        rob_rs2_ready = 1'b1; rob_rs2_val = 32'hCAFEF00D; #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL fwd_rs1_busy got %b want 0", rs1_busy); end
        checks++; if (rs1_val !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_rs1_val got %h want deadbeef", rs1_val); end
        checks++; if (rs2_val !== 32'hCAFEF00D || rs2_busy !== 1'b0) begin errors++; $display("FAIL fwd_rs2 got %h/%b want cafef00d/0", rs2_val, rs2_busy); end
    endtask

    task automatic test_commit_bypass();
        idle();
        rs1_idx = 5'd5;
        write_reg_id = 5'd5; write_val = 32'h1234; write_ROB_id = 4'd3; #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_val !== 32'h1234) begin errors++; $display("FAIL bypass got %h/%b want 1234/0", rs1_val, rs1_busy); end
        tick(); idle(); #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_val !== 32'h1234) begin errors++; $display("FAIL commit_state got %h/%b want 1234/0", rs1_val, rs1_busy); end
        checks++; if (rob_rs1_id !== 4'd0) begin errors++; $display("FAIL commit_rob_id got %0d want 0", rob_rs1_id); end
    endtask

    task automatic test_younger_owner();
        idle(); rs1_idx = 5'd5;
        new_reg_id = 5'd5; new_ROB_id = 4'd3; tick();
        new_ROB_id = 4'd7; tick(); new_reg_id = 5'd0;
        write_reg_id = 5'd5; write_val = 32'hAAAA; write_ROB_id = 4'd3; #1;
        checks++; if (rs1_busy !== 1'b1 || rs1_tag !== 4'd7) begin errors++; $display("FAIL old_commit_no_bypass got %b/%0d want 1/7", rs1_busy, rs1_tag); end
        tick(); idle(); #1;
        checks++; if (rs1_busy !== 1'b1 || rs1_tag !== 4'd7) begin errors++; $display("FAIL younger_owner got %b/%0d want 1/7", rs1_busy, rs1_tag); end
        clear = 1'b1; tick(); clear = 1'b0; #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_val !== 32'hAAAA) begin errors++; $display("FAIL younger_val got %h/%b want aaaa/0", rs1_val, rs1_busy); end
    endtask

    task automatic test_commit_rename_same();
        idle(); rs1_idx = 5'd6;
        new_reg_id = 5'd6; new_ROB_id = 4'd2; tick();
        new_ROB_id = 4'd9; write_reg_id = 5'd6; write_val = 32'h66; write_ROB_id = 4'd2; #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_val !== 32'h66) begin errors++; $display("FAIL same_cycle_bypass got %h/%b want 66/0", rs1_val, rs1_busy); end
        tick(); idle(); #1;
        checks++; if (rs1_busy !== 1'b1 || rs1_tag !== 4'd9) begin errors++; $display("FAIL rename_beats_commit got %b/%0d want 1/9", rs1_busy, rs1_tag); end
        clear = 1'b1; tick(); clear = 1'b0; #1;
        checks++; if (rs1_val !== 32'h66) begin errors++; $display("FAIL same_cycle_val got %h want 66", rs1_val); end
    endtask

    task automatic test_clear();
        idle();
        for (int i = 1; i <= 4; i++) begin
            new_reg_id = 5'(i); new_ROB_id = 4'(i); tick();
        end
        new_reg_id = 5'd8; new_ROB_id = 4'd4; clear = 1'b1;
        write_reg_id = 5'd2; write_val = 32'h55; write_ROB_id = 4'd2;
        tick(); idle();
        rs1_idx = 5'd2; rs2_idx = 5'd8; #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_val !== 32'h55) begin errors++; $display("FAIL clear_x2 got %h/%b want 55/0", rs1_val, rs1_busy); end
        checks++; if (rs2_busy !== 1'b0 || rob_rs2_id !== 4'd0) begin errors++; $display("FAIL clear_x8 got %b/%0d want 0/0", rs2_busy, rob_rs2_id); end
        rs1_idx = 5'd1; rs2_idx = 5'd4; #1;
        checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL clear_x1_x4 got %b/%b want 0/0", rs1_busy, rs2_busy); end
    endtask

    task automatic test_rdy_low();
        idle(); rs1_idx = 5'd7; rs2_idx = 5'd9;
        new_reg_id = 5'd9; new_ROB_id = 4'd1; tick();
        rdy_in = 1'b0; clear = 1'b1;
        write_reg_id = 5'd7; write_val = 32'h77; write_ROB_id = 4'd0;
        new_reg_id = 5'd7; new_ROB_id = 4'd5; tick();
        idle(); #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_val !== 32'd0) begin errors++; $display("FAIL stall_x7 got %h/%b want 0/0", rs1_val, rs1_busy); end
        checks++; if (rs2_busy !== 1'b1 || rs2_tag !== 4'd1) begin errors++; $display("FAIL stall_clear_x9 got %b/%0d want 1/1", rs2_busy, rs2_tag); end
    endtask

    task automatic test_x0();
        idle(); rs1_idx = 5'd0;
        write_reg_id = 5'd0; write_val = 32'hFFFF; new_reg_id = 5'd0; new_ROB_id = 4'd6;
        rob_rs1_ready = 1'b1; rob_rs1_val = 32'h1111; tick(); idle(); #1;
        checks++; if (rs1_busy !== 1'b0 || rs1_val !== 32'd0 || rob_rs1_id !== 4'd0) begin errors++; $display("FAIL x0 got %h/%b/%0d want 0/0/0", rs1_val, rs1_busy, rob_rs1_id); end
    endtask

    initial begin
        rs1_idx = 5'd0; rs2_idx = 5'd0;
        idle();
        test_reset();
        test_rename_forward();
        test_commit_bypass();
        test_younger_owner();
        test_commit_rename_same();
        test_clear();
        test_rdy_low();
        test_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
